// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions used by the receiver and the
//                transmitter: receive FSM state encoding, oversampling
//                constants and the baud divider computation.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Receive FSM state encoding (2 bits)
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // Ticks per bit period and the tick index that lands mid start bit
    localparam int c_OVERSAMPLE = 16;
    localparam int c_MID_START  = 8;

    // System clocks per oversampling tick, truncated
    function automatic int calc_div(input int clk_freq, input int baud_rate,
                                    input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Free-running divider emitting a one-cycle tick every DIV
//                clocks. A clear restarts the count so the first tick after
//                the clear lands DIV cycles later.
//  Ports       : clk      in  system clock
//                rst      in  synchronous active-high reset
//                i_clear  in  restart the divider from 0
//                o_tick   out one-cycle pulse when the count reaches DIV-1
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module baud_tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $fatal(1, "baud_tick_gen: DIV must be at least 2");
        end
    endgenerate

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign o_tick = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, LSB first, 16x oversampled. Each good
//                frame updates o_rx_data and pulses o_rx_done for one cycle;
//                a low stop bit pulses o_frame_error instead.
//  Ports       : i_clock        in  system clock
//                i_reset        in  synchronous active-high reset
//                i_rx           in  asynchronous serial line, idle high
//                o_rx_data      out last good byte, held between frames
//                o_rx_done      out one-cycle strobe, o_rx_data valid
//                o_frame_error  out one-cycle strobe, stop bit sampled low
//                o_busy         out high while a frame is in progress
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int BYTE       = 8,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = c_OVERSAMPLE
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_rx,
    output logic [BYTE-1:0] o_rx_data,
    output logic            o_rx_done,
    output logic            o_frame_error,
    output logic            o_busy
);

    localparam int              c_DIV         = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int              c_BIT_W       = $clog2(BYTE + 1);
    localparam logic [3:0]      c_MID_SAMPLE  = 4'(c_MID_START - 1);
    localparam logic [3:0]      c_LAST_SAMPLE = 4'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(BYTE - 1);

    logic               r_sync_meta;
    logic               r_sync;
    logic [1:0]         r_state;
    logic [3:0]         r_sample_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [BYTE-1:0]    r_shift;
    logic [BYTE-1:0]    r_rx_data;
    logic               r_rx_done;
    logic               r_frame_error;
    logic               w_tick;
    logic               w_start_det;

    // Two-flop synchronizer; reset high so a reset never looks like a start bit
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync_meta <= 1'b1;
            r_sync      <= 1'b1;
        end else begin
            r_sync_meta <= i_rx;
            r_sync      <= r_sync_meta;
        end
    end

    // Restarting the divider on the falling edge aligns ticks to the frame
    assign w_start_det = (r_state == c_ST_IDLE) && !r_sync;

    baud_tick_gen #(
        .DIV (c_DIV)
    ) u_baud_tick_gen (
        .clk     (i_clock),
        .rst     (i_reset),
        .i_clear (w_start_det),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= c_ST_IDLE;
            r_sample_cnt  <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_rx_done     <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_rx_done     <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_det) begin
                        r_state      <= c_ST_START;
                        r_sample_cnt <= '0;
                    end
                end
                c_ST_START: begin
                    if (w_tick) begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                        if (r_sample_cnt == c_MID_SAMPLE) begin
                            if (!r_sync) begin
                                // Realign so every later 16th tick is mid-bit
                                r_state      <= c_ST_DATA;
                                r_sample_cnt <= '0;
                                r_bit_cnt    <= '0;
                            end else begin
                                r_state <= c_ST_IDLE;
                            end
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_tick) begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                        if (r_sample_cnt == c_LAST_SAMPLE) begin
                            r_shift <= {r_sync, r_shift[BYTE-1:1]};
                            if (r_bit_cnt == c_LAST_BIT) begin
                                r_state   <= c_ST_STOP;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                            end
                        end
                    end
                end
                c_ST_STOP: begin
                    if (w_tick) begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                        // Leave mid stop bit so a following start edge is caught
                        if (r_sample_cnt == c_LAST_SAMPLE) begin
                            r_state <= c_ST_IDLE;
                            if (r_sync) begin
                                r_rx_data <= r_shift;
                                r_rx_done <= 1'b1;
                            end else begin
                                r_frame_error <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_rx_data     = r_rx_data;
    assign o_rx_done     = r_rx_done;
    assign o_frame_error = r_frame_error;
    assign o_busy        = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire
